// File: rtl/pc_fetch_sequencer_if.sv
`default_nettype none
// =====================================================================
// Interface : pc_fetch_sequencer_if
// Purpose   : Instruction-memory request/ack handshake of the fetch sequencer.
// Revision  : 1.0
// =====================================================================
interface pc_fetch_sequencer_if #(
    parameter int ADDR_W = 32
);
    logic              imem_req;
    logic [ADDR_W-1:0] imem_addr;
    logic              imem_ack;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack
    );
endinterface
`default_nettype wire

// File: rtl/pc_fetch_sequencer.sv
`default_nettype none
// =====================================================================
// Module   : pc_fetch_sequencer
// Purpose  : Next-PC selection, PC load enable and imem fetch handshake.
// Revision : 1.0
// =====================================================================
module pc_fetch_sequencer #(
    parameter int ADDR_W   = 32,
    parameter int MAX_WAIT = 15
) (
    input  wire                  clk,
    input  wire                  rst,
    input  wire  [ADDR_W-1:0]    pc_cur,
    input  wire  [ADDR_W-1:0]    pc_plus1,
    input  wire                  branch_taken,
    input  wire  [ADDR_W-1:0]    branch_target,
    input  wire                  jump_valid,
    input  wire  [ADDR_W-1:0]    jump_target,
    input  wire                  trap_valid,
    input  wire  [ADDR_W-1:0]    trap_vector,
    input  wire                  stall,
    pc_fetch_sequencer_if.master imem,
    output logic [ADDR_W-1:0]    pc_next,
    output logic                 pc_ready,
    output logic                 instr_valid,
    output logic                 flush,
    output logic                 fetch_error,
    output logic [1:0]           state_dbg
);

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        HOLD = 2'd3
    } state_t;

    localparam int               CNT_W         = 8;
    localparam logic [CNT_W-1:0] c_cnt_max     = '1;
    localparam logic [CNT_W-1:0] c_timeout_cnt = CNT_W'(MAX_WAIT - 1);

    localparam logic [1:0] c_lvl_branch = 2'd1;
    localparam logic [1:0] c_lvl_jump   = 2'd2;
    localparam logic [1:0] c_lvl_trap   = 2'd3;

    state_t              r_state;
    logic [CNT_W-1:0]    r_wait_cnt;
    logic                r_fetch_err;
    logic                r_pend_vld;
    logic [1:0]          r_pend_lvl;
    logic [ADDR_W-1:0]   r_pend_tgt;

    logic                w_live_vld;
    logic [1:0]          w_live_lvl;
    logic [ADDR_W-1:0]   w_live_tgt;
    logic                w_take_live;
    logic                w_redir_vld;
    logic [ADDR_W-1:0]   w_redir_tgt;
    logic                w_timeout;

    // Strongest redirect pulse this cycle; pulses seen in BOOT are discarded.
    always_comb begin
        w_live_vld = 1'b0;
        w_live_lvl = '0;
        w_live_tgt = '0;
        if (r_state != BOOT) begin
            if (trap_valid) begin
                w_live_vld = 1'b1;
                w_live_lvl = c_lvl_trap;
                w_live_tgt = trap_vector;
            end else if (jump_valid) begin
                w_live_vld = 1'b1;
                w_live_lvl = c_lvl_jump;
                w_live_tgt = jump_target;
            end else if (branch_taken) begin
                w_live_vld = 1'b1;
                w_live_lvl = c_lvl_branch;
                w_live_tgt = branch_target;
            end
        end
    end

    // A live pulse beats the pending one only at equal or higher priority.
    assign w_take_live = w_live_vld && (!r_pend_vld || (w_live_lvl >= r_pend_lvl));
    assign w_redir_vld = w_live_vld || r_pend_vld;
    assign w_redir_tgt = w_take_live ? w_live_tgt : r_pend_tgt;

    assign pc_next     = w_redir_vld ? w_redir_tgt : pc_plus1;
    assign pc_ready    = ((r_state == WAIT) && imem.imem_ack && !stall) ||
                         ((r_state == HOLD) && !stall);
    assign flush       = pc_ready && w_redir_vld && (pc_next != pc_plus1);
    assign instr_valid = (r_state == WAIT) && imem.imem_ack && !w_redir_vld;

    // Timeout is visible in the cycle the count of ack-less WAIT cycles hits MAX_WAIT.
    assign w_timeout   = (r_state == WAIT) && !imem.imem_ack &&
                         (r_wait_cnt >= c_timeout_cnt);
    assign fetch_error = r_fetch_err || w_timeout;

    assign imem.imem_req  = (r_state == REQ) || (r_state == WAIT);
    assign imem.imem_addr = pc_cur;
    assign state_dbg      = r_state;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= BOOT;
            r_wait_cnt  <= '0;
            r_fetch_err <= 1'b0;
            r_pend_vld  <= 1'b0;
            r_pend_lvl  <= '0;
            r_pend_tgt  <= '0;
        end else begin
            case (r_state)
                BOOT: r_state <= REQ;
                REQ:  r_state <= WAIT;
                WAIT: begin
                    if (imem.imem_ack) begin
                        r_wait_cnt <= '0;
                        r_state    <= stall ? HOLD : REQ;
                    end else if (r_wait_cnt != c_cnt_max) begin
                        r_wait_cnt <= r_wait_cnt + CNT_W'(1);
                    end
                end
                HOLD: begin
                    if (!stall) begin
                        r_state <= REQ;
                    end
                end
                default: r_state <= BOOT;
            endcase

            if (w_timeout) begin
                r_fetch_err <= 1'b1;
            end

            if (pc_ready) begin
                r_pend_vld <= 1'b0;
            end else if (w_take_live) begin
                r_pend_vld <= 1'b1;
                r_pend_lvl <= w_live_lvl;
                r_pend_tgt <= w_live_tgt;
            end
        end
    end

endmodule
`default_nettype wire
